// File: rtl/traffic_lamp_monitor.sv
//------------------------------------------------------------------------------
// traffic_lamp_monitor: registered lamp driver that latches a fault on unsafe
// controller aspects and flashes red on both approaches until cleared. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module traffic_lamp_monitor #(
  parameter int MIN_YELLOW = 4,
  parameter int GLITCH_CYC = 2,
  parameter int FLASH_HALF = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_signal_red,
  input  logic       main_signal_green,
  input  logic       main_signal_yellow,
  input  logic       side_signal_red,
  input  logic       side_signal_green,
  input  logic       side_signal_yellow,
  input  logic       fault_clr,
  output logic [2:0] lamp_main,
  output logic [2:0] lamp_side,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);

  localparam logic [2:0]    C_RED        = 3'b100;
  localparam logic [2:0]    C_YEL        = 3'b010;
  localparam logic [2:0]    C_GRN        = 3'b001;
  localparam logic [GW-1:0] C_GLITCH_MAX = GW'(GLITCH_CYC);
  localparam logic [YW-1:0] C_YEL_MAX    = YW'(MIN_YELLOW);
  localparam logic [FW-1:0] C_FLASH_LAST = FW'(FLASH_HALF - 1);

  typedef enum logic [0:0] {
    MONITOR = 1'b0,
    FLASH   = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0][2:0]        lamp_q, lamp_d;
  logic [1:0][2:0]        prev_q, prev_d;
  logic [1:0][GW-1:0]     glitch_q, glitch_d;
  logic [1:0][YW-1:0]     yel_q, yel_d;
  logic [FW-1:0]          flash_q, flash_d;
  logic                   flash_off_q, flash_off_d;
  logic [2:0]             code_q, code_d;

  // Index 0 is the main approach, index 1 the side approach.
  logic [1:0][2:0] asp;
  logic [1:0]      valid, go, enc_viol, seq_viol, short_viol;
  logic [2:0]      viol_code;

  assign asp[0] = {main_signal_red, main_signal_yellow, main_signal_green};
  assign asp[1] = {side_signal_red, side_signal_yellow, side_signal_green};

  for (genvar a = 0; a < 2; a++) begin : g_appr
    assign valid[a]      = $onehot(asp[a]);
    assign go[a]         = valid[a] && !asp[a][2];
    assign enc_viol[a]   = !valid[a] && (glitch_q[a] == C_GLITCH_MAX);
    assign seq_viol[a]   = valid[a] && (asp[a] != prev_q[a]) &&
                           !((prev_q[a] == C_RED && asp[a] == C_GRN) ||
                             (prev_q[a] == C_GRN && asp[a] == C_YEL) ||
                             (prev_q[a] == C_YEL && asp[a] == C_RED));
    assign short_viol[a] = valid[a] && (prev_q[a] == C_YEL) &&
                           (asp[a] == C_RED) && (yel_q[a] < C_YEL_MAX);
  end

  // Lowest code wins when several checks fire in the same cycle.
  always_comb begin
    viol_code = 3'd0;
    if (go[0] && go[1])    viol_code = 3'd1;
    else if (|enc_viol)    viol_code = 3'd2;
    else if (|seq_viol)    viol_code = 3'd3;
    else if (|short_viol)  viol_code = 3'd4;
  end

  always_comb begin
    state_d     = state_q;
    lamp_d      = lamp_q;
    prev_d      = prev_q;
    glitch_d    = glitch_q;
    yel_d       = yel_q;
    flash_d     = flash_q;
    flash_off_d = flash_off_q;
    code_d      = code_q;
    case (state_q)
      MONITOR: begin
        if (viol_code != 3'd0) begin
          state_d     = FLASH;
          code_d      = viol_code;
          lamp_d      = {C_RED, C_RED};
          flash_d     = '0;
          flash_off_d = 1'b0;
        end else begin
          for (int a = 0; a < 2; a++) begin
            if (valid[a]) begin
              lamp_d[a]   = asp[a];
              prev_d[a]   = asp[a];
              glitch_d[a] = '0;
              if (asp[a] == C_YEL)
                yel_d[a] = (yel_q[a] == C_YEL_MAX) ? yel_q[a] : yel_q[a] + 1'b1;
              else
                yel_d[a] = '0;
            end else if (glitch_q[a] != C_GLITCH_MAX) begin
              glitch_d[a] = glitch_q[a] + 1'b1;
            end
          end
        end
      end
      FLASH: begin
        if (fault_clr && asp[0] == C_RED && asp[1] == C_RED) begin
          state_d     = MONITOR;
          code_d      = 3'd0;
          lamp_d      = {C_RED, C_RED};
          prev_d      = {C_RED, C_RED};
          glitch_d    = '0;
          yel_d       = '0;
          flash_d     = '0;
          flash_off_d = 1'b0;
        end else if (flash_q == C_FLASH_LAST) begin
          flash_d     = '0;
          flash_off_d = !flash_off_q;
          lamp_d      = flash_off_q ? {C_RED, C_RED} : 6'b000_000;
        end else begin
          flash_d = flash_q + 1'b1;
        end
      end
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MONITOR;
      lamp_q      <= {C_RED, C_RED};
      prev_q      <= {C_RED, C_RED};
      glitch_q    <= '0;
      yel_q       <= '0;
      flash_q     <= '0;
      flash_off_q <= 1'b0;
      code_q      <= 3'd0;
    end else begin
      state_q     <= state_d;
      lamp_q      <= lamp_d;
      prev_q      <= prev_d;
      glitch_q    <= glitch_d;
      yel_q       <= yel_d;
      flash_q     <= flash_d;
      flash_off_q <= flash_off_d;
      code_q      <= code_d;
    end
  end

  assign lamp_main  = lamp_q[0];
  assign lamp_side  = lamp_q[1];
  assign fault      = (state_q == FLASH);
  assign fault_code = code_q;

endmodule

`default_nettype wire
